// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage between decode and execute, with writeback snooping.
// Define OPF_BYPASS_EN to forward snooped write data; otherwise hazards force a register-file re-read.
module operand_fetch #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned PAYLOAD_W = 64
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [REG_AW-1:0]    instr_rs1_i,
    input  logic [REG_AW-1:0]    instr_rs2_i,
    input  logic [PAYLOAD_W-1:0] instr_payload_i,
    output logic                 rf_read_en_o,
    output logic [REG_AW-1:0]    rf_rs1_addr_o,
    output logic [REG_AW-1:0]    rf_rs2_addr_o,
    input  logic [XLEN-1:0]      rf_rs1_data_i,
    input  logic [XLEN-1:0]      rf_rs2_data_i,
    input  logic                 wb_write_en_i,
    input  logic [REG_AW-1:0]    wb_rd_addr_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic                 op_valid_o,
    input  logic                 op_ready_i,
    output logic [XLEN-1:0]      op_rs1_o,
    output logic [XLEN-1:0]      op_rs2_o,
    output logic [PAYLOAD_W-1:0] op_payload_o
);

    typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;

    state_t               state_q, state_d;
    logic [REG_AW-1:0]    rs1_q, rs2_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [XLEN-1:0]      op_rs1_q, op_rs2_q, op_rs1_d, op_rs2_d;
    logic                 hz1_q, hz2_q, hz1_d, hz2_d;
`ifdef OPF_BYPASS_EN
    logic [XLEN-1:0]      hz1_data_q, hz2_data_q, hz1_data_d, hz2_data_d;
`endif

    logic accept, handshake, reread;
    logic in_match1, in_match2, lat_match1, lat_match2;

    assign instr_ready_o = resetn_i & ((state_q == IDLE) | ((state_q == FULL) & op_ready_i));
    assign accept        = instr_valid_i & instr_ready_o;
    assign op_valid_o    = resetn_i & (state_q == FULL);
    assign handshake     = op_valid_o & op_ready_i;

    assign in_match1  = wb_write_en_i & (wb_rd_addr_i == instr_rs1_i) & (instr_rs1_i != '0);
    assign in_match2  = wb_write_en_i & (wb_rd_addr_i == instr_rs2_i) & (instr_rs2_i != '0);
    assign lat_match1 = wb_write_en_i & (wb_rd_addr_i == rs1_q) & (rs1_q != '0);
    assign lat_match2 = wb_write_en_i & (wb_rd_addr_i == rs2_q) & (rs2_q != '0);

`ifdef OPF_BYPASS_EN
    assign reread = 1'b0;
`else
    // The read port returned (or will return) a stale value: issue it again from the latched addresses.
    assign reread = (state_q == CAPTURE) & (hz1_q | hz2_q | lat_match1 | lat_match2);
    logic wb_data_unused;
    assign wb_data_unused = ^wb_data_i;
`endif

    assign rf_read_en_o  = accept | (reread & resetn_i);
    assign rf_rs1_addr_o = reread ? rs1_q : instr_rs1_i;
    assign rf_rs2_addr_o = reread ? rs2_q : instr_rs2_i;

    assign op_rs1_o     = op_rs1_q;
    assign op_rs2_o     = op_rs2_q;
    assign op_payload_o = payload_q;

    always_comb begin
        state_d    = state_q;
        op_rs1_d   = op_rs1_q;
        op_rs2_d   = op_rs2_q;
        hz1_d      = hz1_q;
        hz2_d      = hz2_q;
`ifdef OPF_BYPASS_EN
        hz1_data_d = hz1_data_q;
        hz2_data_d = hz2_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) state_d = CAPTURE;
            end
            CAPTURE: begin
`ifdef OPF_BYPASS_EN
                op_rs1_d = (rs1_q == '0) ? '0 :
                           lat_match1    ? wb_data_i :
                           hz1_q         ? hz1_data_q : rf_rs1_data_i;
                op_rs2_d = (rs2_q == '0) ? '0 :
                           lat_match2    ? wb_data_i :
                           hz2_q         ? hz2_data_q : rf_rs2_data_i;
                hz1_d    = 1'b0;
                hz2_d    = 1'b0;
                state_d  = FULL;
`else
                if (reread) begin
                    hz1_d = lat_match1;
                    hz2_d = lat_match2;
                end else begin
                    op_rs1_d = (rs1_q == '0) ? '0 : rf_rs1_data_i;
                    op_rs2_d = (rs2_q == '0) ? '0 : rf_rs2_data_i;
                    hz1_d    = 1'b0;
                    hz2_d    = 1'b0;
                    state_d  = FULL;
                end
`endif
            end
            FULL: begin
`ifdef OPF_BYPASS_EN
                if (lat_match1) op_rs1_d = wb_data_i;
                if (lat_match2) op_rs2_d = wb_data_i;
`endif
                if (handshake) state_d = accept ? CAPTURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            hz1_d      = in_match1;
            hz2_d      = in_match2;
`ifdef OPF_BYPASS_EN
            hz1_data_d = wb_data_i;
            hz2_data_d = wb_data_i;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            payload_q  <= '0;
            op_rs1_q   <= '0;
            op_rs2_q   <= '0;
            hz1_q      <= 1'b0;
            hz2_q      <= 1'b0;
`ifdef OPF_BYPASS_EN
            hz1_data_q <= '0;
            hz2_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_rs1_q   <= op_rs1_d;
            op_rs2_q   <= op_rs2_d;
            hz1_q      <= hz1_d;
            hz2_q      <= hz2_d;
`ifdef OPF_BYPASS_EN
            hz1_data_q <= hz1_data_d;
            hz2_data_q <= hz2_data_d;
`endif
            if (accept) begin
                rs1_q     <= instr_rs1_i;
                rs2_q     <= instr_rs2_i;
                payload_q <= instr_payload_i;
            end
        end
    end

endmodule
